// File: rtl/jtgng_vga_sched.sv
// VGA-side scheduler for the scan-doubler: H/V sync, ping-pong line RAM read
// addressing and bank selection, with every second line locked to the source LHBL.
module jtgng_vga_sched #(
    parameter int AW      = 8,
    parameter int HS_LEN  = 96,
    parameter int FP_LEN  = 16,
    parameter int LPAD    = 64,
    parameter int RPAD    = 61,
    parameter int BP_LEN  = 48,
    parameter int MAXWAIT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LHBL,
    input  logic          LVBL,
    output logic [AW-1:0] rd_addr,
    output logic          double,
    output logic          rd_sel,
    output logic          wr_bank,
    output logic          wr_en,
    output logic          de,
    output logic          scan_odd,
    output logic          vga_hsync,
    output logic          vga_vsync,
    output logic          unlocked
);

    localparam int ACT_LEN = 2 ** (AW + 1);
    localparam int CMAX    = (MAXWAIT > ACT_LEN) ? MAXWAIT : ACT_LEN;
    localparam int CW      = $clog2(CMAX + 1);

    localparam logic [CW-1:0] HS_M1  = CW'(HS_LEN - 1);
    localparam logic [CW-1:0] FP_M1  = CW'(FP_LEN - 1);
    localparam logic [CW-1:0] LP_M1  = CW'(LPAD - 1);
    localparam logic [CW-1:0] ACT_M1 = CW'(ACT_LEN - 1);
    localparam logic [CW-1:0] RP_M1  = CW'(RPAD - 1);
    localparam logic [CW-1:0] BP_M1  = CW'(BP_LEN - 1);
    localparam logic [CW-1:0] MW_M1  = CW'(MAXWAIT - 1);

    typedef enum logic [2:0] {SYNC, FRONT, LEFT, ACTIVE, RIGHT, BACK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          waitmode;
    logic          vsync_req;
    logic          vcnt;
    logic          first_sync;
    logic          lhbl_meta, lhbl_s, lhbl_last;
    logic          lvbl_meta, lvbl_s, lvbl_last;
    logic          lhbl_rise, lhbl_fall, lvbl_fall;
    logic          cnt_zero;

    assign lhbl_rise = lhbl_s & ~lhbl_last;
    assign lhbl_fall = ~lhbl_s & lhbl_last;
    assign lvbl_fall = ~lvbl_s & lvbl_last;
    assign cnt_zero  = (cnt == '0);
    assign wr_en     = lhbl_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SYNC;
            cnt        <= HS_M1;
            waitmode   <= 1'b0;
            vsync_req  <= 1'b0;
            vcnt       <= 1'b0;
            first_sync <= 1'b1;
            lhbl_meta  <= 1'b0;
            lhbl_s     <= 1'b0;
            lhbl_last  <= 1'b0;
            lvbl_meta  <= 1'b0;
            lvbl_s     <= 1'b0;
            lvbl_last  <= 1'b0;
            rd_addr    <= '0;
            double     <= 1'b0;
            rd_sel     <= 1'b0;
            wr_bank    <= 1'b0;
            de         <= 1'b0;
            scan_odd   <= 1'b0;
            vga_hsync  <= 1'b1;
            vga_vsync  <= 1'b1;
            unlocked   <= 1'b0;
        end else begin
            lhbl_meta <= LHBL;
            lhbl_s    <= lhbl_meta;
            lhbl_last <= lhbl_s;
            lvbl_meta <= LVBL;
            lvbl_s    <= lvbl_meta;
            lvbl_last <= lvbl_s;

            if (lhbl_fall) wr_bank <= ~wr_bank;

            // Outputs follow the current phase one clock later, all aligned together
            vga_hsync            <= (state != SYNC);
            de                   <= (state == ACTIVE);
            {rd_addr, double}    <= (state == ACTIVE) ? ~cnt[AW:0] : '0;

            first_sync <= 1'b0;
            if (state == SYNC && first_sync && vsync_req) begin
                vga_vsync <= 1'b0;
                vsync_req <= 1'b0;
                vcnt      <= 1'b0;
            end else if (lvbl_fall && vga_vsync) begin
                vsync_req <= 1'b1;
            end

            cnt <= cnt - 1'b1;
            case (state)
                SYNC: begin
                    if (waitmode ? (lhbl_rise || cnt_zero) : cnt_zero) begin
                        state    <= FRONT;
                        cnt      <= FP_M1;
                        waitmode <= ~waitmode;
                        if (waitmode) begin
                            rd_sel   <= ~rd_sel;
                            unlocked <= ~lhbl_rise;
                        end
                    end
                end
                FRONT: if (cnt_zero) begin
                    state    <= LEFT;
                    cnt      <= LP_M1;
                    scan_odd <= ~scan_odd;
                end
                LEFT: if (cnt_zero) begin
                    state <= ACTIVE;
                    cnt   <= ACT_M1;
                end
                ACTIVE: if (cnt_zero) begin
                    state <= RIGHT;
                    cnt   <= RP_M1;
                end
                RIGHT: if (cnt_zero) begin
                    state <= BACK;
                    cnt   <= BP_M1;
                end
                BACK: if (cnt_zero) begin
                    state      <= SYNC;
                    cnt        <= waitmode ? MW_M1 : HS_M1;
                    first_sync <= 1'b1;
                    // Second line boundary of a vsync pulse releases it
                    if (!vga_vsync) begin
                        if (vcnt) vga_vsync <= 1'b1;
                        else      vcnt      <= 1'b1;
                    end
                end
                default: begin
                    state <= SYNC;
                    cnt   <= HS_M1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtgng_vga_sched.sv
// Directed bench for jtgng_vga_sched: free-run timing, lock, address sweep,
// vsync windowing, write-side timing and asynchronous reset.
module tb_jtgng_vga_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       LHBL = 1'b1;
    logic       LVBL = 1'b1;
    logic [7:0] rd_addr;
    logic       double, rd_sel, wr_bank, wr_en, de, scan_odd;
    logic       vga_hsync, vga_vsync, unlocked;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    jtgng_vga_sched dut (
        .clk       (clk),
        .rst       (rst),
        .LHBL      (LHBL),
        .LVBL      (LVBL),
        .rd_addr   (rd_addr),
        .double    (double),
        .rd_sel    (rd_sel),
        .wr_bank   (wr_bank),
        .wr_en     (wr_en),
        .de        (de),
        .scan_odd  (scan_odd),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .unlocked  (unlocked)
    );

    always #20 clk = ~clk;

    // Edge index since reset release; a negedge sample after edge N sees cyc == N
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, got, exp, cyc);
        end else begin
            $display("chk  %s: %0d (cyc %0d)", tag, got, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != n) check("wait_cyc", cyc, n);
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return vga_hsync;
            1:       return de;
            default: return 1'b0;
        endcase
    endfunction

    // Number of consecutive samples (including the current one) holding the current value
    task automatic run_len(input int s, output int n);
        logic v;
        v = sig(s);
        n = 0;
        while (sig(s) == v && n < 4000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int bad;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_hsync",    vga_hsync, 1);
        check("rst_vsync",    vga_vsync, 1);
        check("rst_de",       de,        0);
        check("rst_addr",     rd_addr,   0);
        check("rst_rd_sel",   rd_sel,    0);
        check("rst_unlocked", unlocked,  0);
        check("rst_wr_bank",  wr_bank,   0);
        check("rst_scan_odd", scan_odd,  0);

        // Free-running first line
        @(negedge clk);
        run_len(0, n); check("hs_low_l1", n, 96);
        run_len(1, n); check("pre_active_blank", n, 80);
        check("scan_odd_l1", scan_odd, 1);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (int'({rd_addr, double}) != i || de !== 1'b1) bad++;
            @(negedge clk);
        end
        check("addr_sweep_bad", bad, 0);
        check("addr_after_active", rd_addr, 0);
        check("de_after_active", de, 0);
        run_len(0, n); check("hs_high_tail", n, 109);
        check("rd_sel_l1", rd_sel, 0);
        check("unlocked_l1", unlocked, 0);

        // Second SYNC waits with no LHBL edge and times out
        run_len(0, n); check("wait_timeout", n, 1023);
        check("unlocked_timeout", unlocked, 1);
        check("rd_sel_timeout", rd_sel, 1);

        // Write side: LHBL falls before edge 1830
        wait_cyc(1829); LHBL = 1'b0;
        wait_cyc(1830); check("wr_en_fall_1", wr_en, 1);
        wait_cyc(1831); check("wr_en_fall_2", wr_en, 0); check("wr_bank_hold", wr_bank, 0);
        wait_cyc(1832); check("wr_bank_toggle", wr_bank, 1);

        // Lock: waiting SYNC starts at 3318, LHBL rises before edge 3330
        wait_cyc(3318); check("lock1_pre_hs", vga_hsync, 1);
        wait_cyc(3319); check("lock1_wait_hs", vga_hsync, 0);
        wait_cyc(3329); LHBL = 1'b1;
        wait_cyc(3330); check("wr_en_rise_1", wr_en, 0);
        wait_cyc(3331); check("wr_en_rise_2", wr_en, 1);
        wait_cyc(3332); check("lock1_hs_low", vga_hsync, 0);
        wait_cyc(3333); check("lock1_hs_end", vga_hsync, 1);
        check("lock1_unlocked", unlocked, 0);
        check("lock1_rd_sel", rd_sel, 0);

        // Next line pair, LHBL period 1600
        wait_cyc(4129); check("rd_sel_mid_pair", rd_sel, 0); LHBL = 1'b0;
        wait_cyc(4132); check("wr_bank_toggle2", wr_bank, 0);
        wait_cyc(4830); check("lock2_pre_hs", vga_hsync, 1);
        wait_cyc(4831); check("lock2_wait_hs", vga_hsync, 0);
        wait_cyc(4929); LHBL = 1'b1;
        wait_cyc(4932); check("lock2_hs_low", vga_hsync, 0);
        wait_cyc(4933); check("lock2_hs_end", vga_hsync, 1);
        check("lock2_rd_sel", rd_sel, 1);
        check("lock2_unlocked", unlocked, 0);

        // Vsync: request before the SYNC starting at 5633
        wait_cyc(4999); LVBL = 1'b0;
        wait_cyc(5633); check("vs_before", vga_vsync, 1);
        wait_cyc(5634); check("vs_start", vga_vsync, 0); check("vs_start_hs", vga_hsync, 0);
        wait_cyc(5999); LVBL = 1'b1;
        wait_cyc(6499); LVBL = 1'b0;
        wait_cyc(8153); check("vs_last_low", vga_vsync, 0);
        wait_cyc(8154); check("vs_end", vga_vsync, 1);
        check("unlocked_timeout2", unlocked, 1);
        wait_cyc(8160); check("vs_no_repeat", vga_vsync, 1);

        // Asynchronous reset in the middle of ACTIVE
        wait_cyc(8400);
        check("mid_active_de", de, 1);
        check("mid_active_addr", rd_addr, 34);
        rst = 1'b1;
        #1;
        check("arst_addr", rd_addr, 0);
        check("arst_de", de, 0);
        check("arst_hsync", vga_hsync, 1);
        check("arst_vsync", vga_vsync, 1);
        check("arst_rd_sel", rd_sel, 0);
        check("arst_unlocked", unlocked, 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
